// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue.
//   WB_ADDR_W / WB_DATA_W : default register address / data widths
//   wb_entry_t            : one pending writeback {addr, data}
//   ptr_w()               : pointer width derived from the queue depth
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 6;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wbq_lookup.sv
// Age-ordered forwarding match over the writeback queue storage.
//   valid   : per-slot valid mask (contiguous run starting at head)
//   head    : slot index of the oldest entry
//   entries : queue storage
//   la      : lookup address (address 0 never hits)
//   hit, fd : match flag and youngest matching data (0 when no hit)
module wbq_lookup
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic [DEPTH-1:0]     valid,
    input  logic [PTR_W-1:0]     head,
    input  wb_entry_t            entries [DEPTH],
    input  logic [WB_ADDR_W-1:0] la,
    output logic                 hit,
    output logic [WB_DATA_W-1:0] fd
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overrides an older one.
    always_comb begin
        hit = 1'b0;
        fd  = '0;
        idx = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (la != '0) && (entries[idx].addr == la)) begin
                hit = 1'b1;
                fd  = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue in front of the 2R/1W register file.
// Buffers writebacks, drains one per cycle into the write port, and forwards
// pending values to both read addresses.
//   clk, rst_n                      : clock, async active-low reset
//   push_valid/ready/addr/data      : writeback producer handshake
//   flush                           : synchronous discard of pending entries
//   we3, a3, wd3                    : regfile write port (head entry)
//   la1/la2 -> hit1/fd1, hit2/fd2   : forwarding lookups for regfile a1/a2
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] la1,
    input  logic [ADDR_W-1:0] la2,
    output logic              hit1,
    output logic [DATA_W-1:0] fd1,
    output logic              hit2,
    output logic [DATA_W-1:0] fd2
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;
    wb_entry_t       mem_q [DEPTH];

    logic             push_fire, alloc, pop;
    logic [DEPTH-1:0] valid;
    logic [PtrW-1:0]  off;

    // Conservative: a full queue refuses pushes even while it pops.
    assign push_ready = (count_q != CntW'(DEPTH)) && !flush;
    assign push_fire  = push_valid && push_ready;
    // Writes to x0 are accepted but never occupy a slot.
    assign alloc      = push_fire && (push_addr != '0);
    // The regfile always accepts, so any pending entry pops every cycle.
    assign pop        = (count_q != '0);

    assign we3 = pop;
    assign a3  = pop ? mem_q[head_q].addr : '0;
    assign wd3 = pop ? mem_q[head_q].data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PtrW'(pop);
            tail_q  <= tail_q + PtrW'(alloc);
            count_q <= count_q + CntW'(alloc) - CntW'(pop);
        end
    end

    // Storage is not reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_q[tail_q].addr <= push_addr;
            mem_q[tail_q].data <= push_data;
        end
    end

    // A slot is valid when its distance from head is below count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off      = PtrW'(i) - head_q;
            valid[i] = (CntW'(off) < count_q);
        end
    end

    wbq_lookup #(
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_lookup1 (
        .valid   (valid),
        .head    (head_q),
        .entries (mem_q),
        .la      (la1),
        .hit     (hit1),
        .fd      (fd1)
    );

    wbq_lookup #(
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_lookup2 (
        .valid   (valid),
        .head    (head_q),
        .entries (mem_q),
        .la      (la2),
        .hit     (hit2),
        .fd      (fd2)
    );

endmodule
